// File: rtl/i2s_mixer.sv
// N-channel stereo mixer (serial multiply-accumulate) feeding a 64-slot I2S transmitter.
// Define SATURATE_EN to clamp the mixed words; otherwise they wrap to OW bits.
module i2s_mixer #(
  parameter int CHANNELS = 4,
  parameter int IW       = 16,
  parameter int OW       = 16,
  parameter int DIV      = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [CHANNELS*IW-1:0] chl,
  input  logic [CHANNELS*IW-1:0] chr,
  input  logic [CHANNELS-1:0]    uns,
  input  logic [CHANNELS*4-1:0]  vol,
  output logic                   sample,
  output logic [2:0]             i2s
);

  localparam int CLG = $clog2(CHANNELS);
  localparam int AW  = IW + 4 + CLG;
  localparam int EW  = AW + 32;
  localparam int SH  = (IW > OW) ? (4 + IW - OW) : 4;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int KW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [KW-1:0] K_LAST  = KW'(CHANNELS - 1);
  localparam logic [5:0]    OW6     = 6'(OW);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_SCALE} state_t;

  logic [PW-1:0] r_pre;
  logic          r_sck;
  logic          r_ws;
  logic          r_sd;
  logic [5:0]    r_bit;
  logic          r_slot0;

  logic [CHANNELS*IW-1:0] r_chl;
  logic [CHANNELS*IW-1:0] r_chr;
  logic [CHANNELS-1:0]    r_uns;
  logic [CHANNELS*4-1:0]  r_vol;
  logic [KW-1:0]          r_k;
  logic signed [AW-1:0]   r_acc_l;
  logic signed [AW-1:0]   r_acc_r;
  logic [OW-1:0]          r_pend_l;
  logic [OW-1:0]          r_pend_r;
  logic [OW-1:0]          r_out_l;
  logic [OW-1:0]          r_out_r;
  state_t                 r_state;

  state_t               w_state_nxt;
  logic                 w_acc_en;
  logic                 w_scale_en;
  logic                 w_tick;
  logic                 w_fall;
  logic                 w_cap;
  logic [5:0]           w_bit_nxt;
  logic [5:0]           w_n;
  logic [OW-1:0]        w_word;
  logic [OW-1:0]        w_mask;
  logic                 w_in_rng;
  logic                 w_sd_nxt;
  logic [IW-1:0]        w_msb;
  logic [IW-1:0]        w_l_s;
  logic [IW-1:0]        w_r_s;
  logic [3:0]           w_vk;
  logic signed [AW-1:0] w_lx;
  logic signed [AW-1:0] w_rx;
  logic signed [AW-1:0] w_vx;
  logic signed [AW-1:0] w_prod_l;
  logic signed [AW-1:0] w_prod_r;
  logic signed [EW-1:0] w_al_l;
  logic signed [EW-1:0] w_al_r;

  // Slot 0 is entered out of reset and on every 63->0 wrap; inputs are taken at the end of that cycle.
  assign w_tick    = (r_pre == PRE_MAX);
  assign w_fall    = w_tick & r_sck;
  assign w_cap     = r_slot0 & ~reset;
  assign sample    = w_cap;
  assign i2s       = {r_sck, r_ws, r_sd};

  assign w_bit_nxt = r_bit + 6'd1;
  assign w_n       = {1'b0, w_bit_nxt[4:0]};
  assign w_word    = w_bit_nxt[5] ? r_out_r : r_out_l;
  assign w_in_rng  = (w_n != 6'd0) && (w_n <= OW6);
  assign w_mask    = OW'(1) << (OW6 - w_n);
  assign w_sd_nxt  = w_in_rng & (|(w_word & w_mask));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pre   <= '0;
      r_sck   <= 1'b0;
      r_ws    <= 1'b0;
      r_sd    <= 1'b0;
      r_bit   <= 6'd0;
      r_slot0 <= 1'b1;
    end else begin
      r_slot0 <= w_fall && (r_bit == 6'd63);
      if (w_tick) begin
        r_pre <= '0;
        r_sck <= ~r_sck;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
      if (w_fall) begin
        r_bit <= w_bit_nxt;
        r_ws  <= w_bit_nxt[5];
        r_sd  <= w_sd_nxt;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_cap) begin
      w_state_nxt = S_ACC;
    end else begin
      case (r_state)
        S_ACC:   if (r_k == K_LAST) w_state_nxt = S_SCALE;
        S_SCALE: w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_acc_en   = 1'b0;
    w_scale_en = 1'b0;
    case (r_state)
      S_ACC:   w_acc_en   = 1'b1;
      S_SCALE: w_scale_en = 1'b1;
      default: ;
    endcase
  end

  // Offset-binary becomes two's complement by flipping the MSB; volume is an unsigned multiplier.
  assign w_msb    = {1'b1, {(IW-1){1'b0}}};
  assign w_vk     = r_vol[r_k*4 +: 4];
  assign w_l_s    = r_chl[r_k*IW +: IW] ^ (r_uns[r_k] ? w_msb : '0);
  assign w_r_s    = r_chr[r_k*IW +: IW] ^ (r_uns[r_k] ? w_msb : '0);
  assign w_lx     = AW'($signed(w_l_s));
  assign w_rx     = AW'($signed(w_r_s));
  assign w_vx     = AW'({1'b0, w_vk});
  assign w_prod_l = w_lx * w_vx;
  assign w_prod_r = w_rx * w_vx;

  assign w_al_l   = EW'(r_acc_l) >>> SH;
  assign w_al_r   = EW'(r_acc_r) >>> SH;

`ifdef SATURATE_EN
  localparam logic signed [EW-1:0] SMAX = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [EW-1:0] SMIN = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  function automatic logic [OW-1:0] limit(input logic signed [EW-1:0] v);
    if (v > SMAX)      return SMAX[OW-1:0];
    else if (v < SMIN) return SMIN[OW-1:0];
    else               return OW'(v);
  endfunction
`else
  function automatic logic [OW-1:0] limit(input logic signed [EW-1:0] v);
    return OW'(v);
  endfunction
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_chl    <= '0;
      r_chr    <= '0;
      r_uns    <= '0;
      r_vol    <= '0;
      r_k      <= '0;
      r_acc_l  <= '0;
      r_acc_r  <= '0;
      r_pend_l <= '0;
      r_pend_r <= '0;
      r_out_l  <= '0;
      r_out_r  <= '0;
    end else if (w_cap) begin
      r_chl   <= chl;
      r_chr   <= chr;
      r_uns   <= uns;
      r_vol   <= vol;
      r_out_l <= r_pend_l;
      r_out_r <= r_pend_r;
      r_acc_l <= '0;
      r_acc_r <= '0;
      r_k     <= '0;
    end else begin
      if (w_acc_en) begin
        r_acc_l <= r_acc_l + w_prod_l;
        r_acc_r <= r_acc_r + w_prod_r;
        r_k     <= r_k + 1'b1;
      end
      if (w_scale_en) begin
        r_pend_l <= limit(w_al_l);
        r_pend_r <= limit(w_al_r);
      end
    end
  end

endmodule

// File: tb/tb_i2s_mixer.sv
// Directed bench for i2s_mixer: per-cycle scoreboard of {sck,ws,sd,sample} plus literal checks of received words.
module tb_i2s_mixer;
  localparam int CH  = 2;
  localparam int IW  = 16;
  localparam int OW  = 16;
  localparam int DIV = 2;
  localparam int FRAME = 128 * DIV;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [15:0] in_l [CH];
  logic [15:0] in_r [CH];
  logic        in_u [CH];
  logic [3:0]  in_v [CH];
  logic [CH*IW-1:0] chl;
  logic [CH*IW-1:0] chr;
  logic [CH-1:0]    uns;
  logic [CH*4-1:0]  vol;
  logic             sample;
  logic [2:0]       i2s;

  always_comb begin
    chl = '0;
    chr = '0;
    uns = '0;
    vol = '0;
    for (int k = 0; k < CH; k++) begin
      chl[k*IW +: IW] = in_l[k];
      chr[k*IW +: IW] = in_r[k];
      uns[k]          = in_u[k];
      vol[k*4 +: 4]   = in_v[k];
    end
  end

  i2s_mixer #(.CHANNELS(CH), .IW(IW), .OW(OW), .DIV(DIV)) dut (
    .clock(clock), .reset(reset), .chl(chl), .chr(chr),
    .uns(uns), .vol(vol), .sample(sample), .i2s(i2s)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic longint sval(input logic [15:0] x, input logic u);
    if (u) return longint'(x) - 32768;
    else   return longint'($signed(x));
  endfunction

  // Reference mix: exact integer sum, floor-divide by 16, then clamp or wrap to 16 bits.
  function automatic logic [15:0] mix2(input logic [15:0] a0, input logic [15:0] a1,
                                       input logic u0, input logic u1,
                                       input logic [3:0] v0, input logic [3:0] v1);
    longint acc;
    longint q;
    acc = sval(a0, u0) * longint'(v0) + sval(a1, u1) * longint'(v1);
    q   = acc >>> 4;
`ifdef SATURATE_EN
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
`endif
    return q[15:0];
  endfunction

  task automatic set_ch(input int k, input logic [15:0] l, input logic [15:0] r,
                        input logic u, input logic [3:0] v);
    in_l[k] = l;
    in_r[k] = r;
    in_u[k] = u;
    in_v[k] = v;
  endtask

  // Scoreboard state
  int          t = 0;
  bit          started = 0;
  logic [15:0] cur_l = '0, cur_r = '0, pend_l = '0, pend_r = '0;
  logic [15:0] rx_l = '0, rx_r = '0;
  logic [15:0] rec_l [8];
  logic [15:0] rec_r [8];
  int          ridx = 0;

  initial begin
    for (int i = 0; i < 8; i++) begin
      rec_l[i] = 16'hDEAD;
      rec_r[i] = 16'hDEAD;
    end
    forever begin
      @(posedge clock);
      if (reset) begin
        t = 0;
        started = 1;
        cur_l = '0; cur_r = '0; pend_l = '0; pend_r = '0;
      end else if (started) begin
        if (t % FRAME == FRAME - 1 && ridx < 8) begin
          rec_l[ridx] = rx_l;
          rec_r[ridx] = rx_r;
          ridx++;
        end
        if (t % FRAME == 0) begin
          cur_l  = pend_l;
          cur_r  = pend_r;
          pend_l = mix2(in_l[0], in_l[1], in_u[0], in_u[1], in_v[0], in_v[1]);
          pend_r = mix2(in_r[0], in_r[1], in_u[0], in_u[1], in_v[0], in_v[1]);
        end
        t++;
      end
      @(negedge clock);
      if (started) begin
        int slot;
        int n;
        logic ws_e, sck_e, sd_e, samp_e;
        logic [15:0] w;
        slot   = (t / (2 * DIV)) % 64;
        n      = slot % 32;
        ws_e   = (slot >= 32);
        sck_e  = ((t / DIV) % 2) == 1;
        w      = ws_e ? cur_r : cur_l;
        sd_e   = (n >= 1 && n <= OW) ? w[OW-n] : 1'b0;
        samp_e = (t % FRAME == 0) && !reset;
        check($sformatf("i2s t=%0d", t), {29'd0, i2s}, {29'd0, sck_e, ws_e, sd_e});
        check($sformatf("sample t=%0d", t), {31'd0, sample}, {31'd0, samp_e});
        if (t % FRAME == 0) begin
          rx_l = '0;
          rx_r = '0;
        end
        if (t % (2 * DIV) == 0 && n >= 1 && n <= OW) begin
          if (slot < 32) rx_l[OW-n] = i2s[0];
          else           rx_r[OW-n] = i2s[0];
        end
      end
    end
  end

  task automatic advance(input int cycles);
    repeat (cycles) @(posedge clock);
    #1;
  endtask

  logic [15:0] exp_l2, exp_r2;

  initial begin
`ifdef SATURATE_EN
    exp_l2 = 16'h7FFF;
    exp_r2 = 16'h8000;
`else
    exp_l2 = 16'hEFFE;
    exp_r2 = 16'h1000;
`endif
    // Pin the reference model against hand-computed words
    check("model ch0 4096*15", {16'd0, mix2(16'h1000, 16'h1234, 1'b0, 1'b0, 4'd15, 4'd0)}, 32'h0F00);
    check("model full scale L", {16'd0, mix2(16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 4'd15, 4'd15)}, {16'd0, exp_l2});
    check("model full scale R", {16'd0, mix2(16'h8000, 16'h8000, 1'b0, 1'b0, 4'd15, 4'd15)}, {16'd0, exp_r2});
    check("model uns zero", {16'd0, mix2(16'h0000, 16'h5555, 1'b1, 1'b0, 4'd15, 4'd0)}, 32'h8800);
    check("model uns mid", {16'd0, mix2(16'h8000, 16'h5555, 1'b1, 1'b0, 4'd15, 4'd0)}, 32'h0000);
    check("model floor -1", {16'd0, mix2(16'hFFFF, 16'h7777, 1'b0, 1'b0, 4'd1, 4'd0)}, 32'hFFFF);
    check("model small", {16'd0, mix2(16'h0010, 16'h7777, 1'b0, 1'b0, 4'd1, 4'd0)}, 32'h0001);

    // Captured at release, sent in frame 1
    set_ch(0, 16'h1000, 16'h0000, 1'b0, 4'd15);
    set_ch(1, 16'h1234, 16'h7FFF, 1'b1, 4'd0);
    reset = 1'b1;
    advance(5);
    reset = 1'b0;
    advance(128);
    set_ch(0, 16'h7FFF, 16'h8000, 1'b0, 4'd15);
    set_ch(1, 16'h7FFF, 16'h8000, 1'b0, 4'd15);
    advance(256);
    set_ch(0, 16'h0000, 16'h8000, 1'b1, 4'd15);
    set_ch(1, 16'h5555, 16'h5555, 1'b0, 4'd0);
    advance(256);
    set_ch(0, 16'h0010, 16'hFFFF, 1'b0, 4'd1);
    set_ch(1, 16'h7777, 16'h7777, 1'b0, 4'd0);
    advance(256);
    set_ch(0, 16'h4000, 16'hC000, 1'b0, 4'd8);
    set_ch(1, 16'h0100, 16'h0000, 1'b0, 4'd4);
    advance(256);
    set_ch(0, 16'h0800, 16'h0800, 1'b0, 4'd2);
    set_ch(1, 16'hFFFF, 16'hFFFF, 1'b1, 4'd0);
    advance(288);
    // t=1440 is slot 40 of frame 5: abort it with a 3-clock reset
    reset = 1'b1;
    advance(3);
    reset = 1'b0;
    advance(530);

    check("frame0 L", {16'd0, rec_l[0]}, 32'h0000);
    check("frame0 R", {16'd0, rec_r[0]}, 32'h0000);
    check("frame1 L", {16'd0, rec_l[1]}, 32'h0F00);
    check("frame1 R", {16'd0, rec_r[1]}, 32'h0000);
    check("frame2 L", {16'd0, rec_l[2]}, {16'd0, exp_l2});
    check("frame2 R", {16'd0, rec_r[2]}, {16'd0, exp_r2});
    check("frame3 L", {16'd0, rec_l[3]}, 32'h8800);
    check("frame3 R", {16'd0, rec_r[3]}, 32'h0000);
    check("frame4 L", {16'd0, rec_l[4]}, 32'h0001);
    check("frame4 R", {16'd0, rec_r[4]}, 32'hFFFF);
    check("post-reset frame0 L", {16'd0, rec_l[5]}, 32'h0000);
    check("post-reset frame0 R", {16'd0, rec_r[5]}, 32'h0000);
    check("post-reset frame1 L", {16'd0, rec_l[6]}, 32'h0100);
    check("post-reset frame1 R", {16'd0, rec_r[6]}, 32'h0100);
    check("frames recorded", ridx, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_mixer.md
Name: i2s_mixer

Overview:
Parametrised N-channel stereo audio mixer with integrated I2S transmitter. It replaces the fixed two-source adder and encoder pair at board top level.
- Each channel carries left/right samples, a signed/unsigned flag and a 4-bit volume.
- Channels are accumulated sequentially, scaled and range-limited, then serialised as a 64-bit-per-frame I2S stream.
- It sits between the core's audio outputs, the external I2S/MIDI decoder and the board DAC pins.

Parameters:
CHANNELS, 4, number of stereo input channels (1..8)
IW, 16, input sample width per channel side
OW, 16, output word width (<=31)
DIV, 2, clock cycles per half period of the bit clock (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
chl  in  CHANNELS*IW  left samples, channel k at [k*IW +: IW]
chr  in  CHANNELS*IW  right samples, same packing
uns  in  CHANNELS  1 = channel k is unsigned offset-binary, 0 = two's complement
vol  in  CHANNELS*4  gain of channel k at [k*4 +: 4]; gain = vol/16, 0 = mute
sample  out  1  one-clock pulse when inputs are captured
i2s  out  3  {sck, ws, sd}

Behaviour:
Reset:
- sck=0, ws=0, sd=0, sample=0.
- Prescaler, bit counter, accumulators, shift register and output words all cleared.
- Reset mid-frame aborts the frame and any mix in progress. The next frame restarts from slot 0.

Clocking:
- Prescaler counts 0..DIV-1. At DIV-1 it wraps and sck toggles, so the sck period is 2*DIV clocks.
- Bit counter (6 bits) advances on each sck falling transition. It wraps 63->0 at 64 slots per frame.
- ws and sd update only on sck falling transitions. Slot counter 0..31 gives ws=0 (left); 32..63 gives ws=1 (right).

Serial data (I2S one-bit delay):
- In half-slot n (0..31), sd = word[OW-n] for 1<=n<=OW; otherwise sd = 0. MSB is sent first.
- word is the left output word in the left half and the right output word in the right half.

Capture:
- Occurs in the cycle the bit counter enters slot 0. This is also the first cycle after reset deasserts.
- chl/chr/uns/vol are registered and sample pulses high for 1 clock.

Mix engine, FSM states IDLE -> ACC -> SCALE -> IDLE:
- IDLE: waits for capture.
- ACC: one channel per clock, k = 0..CHANNELS-1. Each sample is converted to signed (if uns[k], MSB is inverted), sign-extended, multiplied by vol[k] as unsigned, and added to per-side accumulators of width IW+4+clog2(CHANNELS).
- SCALE: arithmetic shift right 4 (floor), sign-aligned to OW by keeping the top bits when IW>OW or sign-extending when IW<OW. Range-limited to OW (see optional feature), then written into pending words.
- Return to IDLE.
- Pending words transfer to output words at the next capture. Latency is therefore one frame: samples captured at frame N are transmitted in frame N+1. The first frame after reset transmits zeros.

Timing and boundary rules:
- Mix completes in CHANNELS+2 clocks. Requirement: CHANNELS+2 < 128*DIV, always met within parameter ranges.
- Input changes between captures are ignored.
- vol = 0 contributes exactly 0 regardless of sample or uns.
- If a capture coincides with SCALE (impossible under the constraint), capture wins and the FSM restarts ACC.

Optional Feature:
SATURATE_EN
- Defined: the scaled sum is clamped to [-2^(OW-1), 2^(OW-1)-1].
- Undefined: the scaled sum is truncated to its low OW bits (two's-complement wrap), saving comparators.

Test Plan:
Parameters for all scenarios: CHANNELS=2, IW=16, OW=16, DIV=2 (sck period 4 clocks, frame 256 clocks).

1. Reset then release -> sck/ws/sd low during reset; sample pulses on first clock after release and every 256 clocks; ws toggles every 128 clocks; first frame sd all zero.
2. ch0 L=16'h1000, uns=0, vol=15; ch1 vol=0 -> next frame left word 16'h0F00: sd bits 1..16 of left half = 0000111100000000; right word 0.
3. Both channels L=16'h7FFF, vol=15 -> left word 16'h7FFF with SATURATE_EN; 16'hEFFE without.
4. ch0 uns=1, L=16'h0000, vol=15; ch1 muted -> left word 16'h8800. With L=16'h8000 -> 16'h0000.
5. ch0 R=16'hFFFF signed (-1), vol=1 -> right word 16'hFFFF (floor of -1/16); L=16'h0010 vol=1 -> left 16'h0001.
6. Assert reset for 3 clocks at slot 40 with nonzero samples -> outputs low next clock; after release the frame restarts at slot 0, transmits zeros, then new capture data.
